// File: rtl/board_row_server_if.sv
// Row-fetch and cell-write bundle between the colour mapper / game logic
// (master) and the board row server (slave).
interface board_row_server_if #(
  parameter int BOARD_WIDTH = 10,
  parameter int CELL_W      = 16
);
  logic              LD_Row;
  logic [7:0]        rowNum;
  logic [CELL_W-1:0] Row [BOARD_WIDTH];
  logic              rowReady;
  logic              busy;
  logic              wr_en;
  logic [4:0]        wr_row;
  logic [3:0]        wr_col;
  logic [CELL_W-1:0] wr_data;

  modport master (
    output LD_Row, rowNum, wr_en, wr_row, wr_col, wr_data,
    input  Row, rowReady, busy
  );

  modport slave (
    input  LD_Row, rowNum, wr_en, wr_row, wr_col, wr_data,
    output Row, rowReady, busy
  );
endinterface

// File: rtl/board_row_server.sv
// Board cell memory with atomic row fetch into Row[] for the colour mapper.
// Optional BOARD_CLEAR_EN: after reset, sweep EMPTY_COLOR into every cell.
module board_row_server #(
  parameter int                BOARD_WIDTH  = 10,
  parameter int                BOARD_HEIGHT = 20,
  parameter int                CELL_W       = 16,
  parameter logic [CELL_W-1:0] EMPTY_COLOR  = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  board_row_server_if.slave  bus
);

  localparam int                 COL_W     = $clog2(BOARD_WIDTH);
  localparam int                 ROW_AW    = $clog2(BOARD_HEIGHT);
  localparam logic [COL_W-1:0]   COL_ZERO  = '0;
  localparam logic [COL_W-1:0]   COL_ONE   = COL_W'(1);
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(BOARD_WIDTH - 1);
  localparam logic [7:0]         HEIGHT_8  = 8'(BOARD_HEIGHT);
  localparam logic [4:0]         HEIGHT_5  = 5'(BOARD_HEIGHT);
  localparam logic [3:0]         WIDTH_4   = 4'(BOARD_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [7:0]        req_row_q, req_row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_row_q, pend_row_d;
  logic [CELL_W-1:0] shadow_q [BOARD_WIDTH];
  logic [CELL_W-1:0] shadow_d [BOARD_WIDTH];
  logic [CELL_W-1:0] row_q [BOARD_WIDTH];
  logic [CELL_W-1:0] row_d [BOARD_WIDTH];
  logic [CELL_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
`ifdef BOARD_CLEAR_EN
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(BOARD_HEIGHT - 1);
  localparam logic [ROW_AW-1:0] ROW_ONE  = ROW_AW'(1);
  logic [ROW_AW-1:0] clr_row_q, clr_row_d;
  logic [COL_W-1:0]  clr_col_q, clr_col_d;
`endif

  logic [CELL_W-1:0] mem_q [BOARD_HEIGHT][BOARD_WIDTH];
  logic              mem_we_s;
  logic [ROW_AW-1:0] mem_row_s;
  logic [COL_W-1:0]  mem_col_s;
  logic [CELL_W-1:0] mem_wdata_s;
  logic              rd_oor_s;

  assign rd_oor_s     = (req_row_q >= HEIGHT_8);
  assign bus.Row      = row_q;
  assign bus.rowReady = rdy_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
`ifdef BOARD_CLEAR_EN
      state_q   <= S_CLEAR;
      busy_q    <= 1'b1;
      clr_row_q <= '0;
      clr_col_q <= '0;
`else
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
`endif
      req_row_q  <= 8'h00;
      col_q      <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= 8'h00;
      rd_data_q  <= '0;
      rdy_q      <= 1'b0;
      for (int i = 0; i < BOARD_WIDTH; i++) begin
        shadow_q[i] <= '0;
        row_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      req_row_q  <= req_row_d;
      col_q      <= col_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      rd_data_q  <= rd_data_d;
      rdy_q      <= rdy_d;
      shadow_q   <= shadow_d;
      row_q      <= row_d;
`ifdef BOARD_CLEAR_EN
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
`endif
    end
  end

  // Reads are registered from mem_q in the same edge a write lands, so a
  // same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we_s) begin
      mem_q[mem_row_s][mem_col_s] <= mem_wdata_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_row_d  = req_row_q;
    col_d      = col_q;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    shadow_d   = shadow_q;
    row_d      = row_q;
    rd_data_d  = rd_data_q;
    rdy_d      = 1'b0;
`ifdef BOARD_CLEAR_EN
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.LD_Row) begin
          req_row_d = bus.rowNum;
          col_d     = COL_ZERO;
          state_d   = S_READ;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_READ: begin
        if (bus.LD_Row) begin
          pend_d     = 1'b1;
          pend_row_d = bus.rowNum;
        end else begin
          pend_d     = pend_q;
        end
        rd_data_d = rd_oor_s ? EMPTY_COLOR : mem_q[req_row_q[ROW_AW-1:0]][col_q];
        if (col_q != COL_ZERO) begin
          shadow_d[col_q - COL_ONE] = rd_data_q;
        end else begin
          shadow_d = shadow_q;
        end
        if (col_q == COL_LAST) begin
          state_d = S_DRAIN;
        end else begin
          col_d   = col_q + COL_ONE;
        end
      end
      S_DRAIN: begin
        // Whole row lands in one edge; last cell comes straight from the read register.
        for (int i = 0; i < BOARD_WIDTH - 1; i++) begin
          row_d[i] = shadow_q[i];
        end
        row_d[BOARD_WIDTH-1] = rd_data_q;
        rdy_d = 1'b1;
        if (bus.LD_Row) begin
          req_row_d = bus.rowNum;
          col_d     = COL_ZERO;
          pend_d    = 1'b0;
          state_d   = S_READ;
        end else if (pend_q) begin
          req_row_d = pend_row_q;
          col_d     = COL_ZERO;
          pend_d    = 1'b0;
          state_d   = S_READ;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_CLEAR: begin
`ifdef BOARD_CLEAR_EN
        if (bus.LD_Row) begin
          pend_d     = 1'b1;
          pend_row_d = bus.rowNum;
        end else begin
          pend_d     = pend_q;
        end
        if (clr_col_q != COL_LAST) begin
          clr_col_d = clr_col_q + COL_ONE;
        end else if (clr_row_q != ROW_LAST) begin
          clr_col_d = COL_ZERO;
          clr_row_d = clr_row_q + ROW_ONE;
        end else if (pend_d) begin
          req_row_d = pend_row_d;
          col_d     = COL_ZERO;
          pend_d    = 1'b0;
          state_d   = S_READ;
        end else begin
          state_d   = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    mem_we_s    = 1'b0;
    mem_row_s   = ROW_AW'(bus.wr_row);
    mem_col_s   = COL_W'(bus.wr_col);
    mem_wdata_s = bus.wr_data;
`ifdef BOARD_CLEAR_EN
    if (state_q == S_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_row_s   = clr_row_q;
      mem_col_s   = clr_col_q;
      mem_wdata_s = EMPTY_COLOR;
    end else if (bus.wr_en && (bus.wr_row < HEIGHT_5) && (bus.wr_col < WIDTH_4)) begin
      mem_we_s    = 1'b1;
    end else begin
      mem_we_s    = 1'b0;
    end
`else
    if (bus.wr_en && (bus.wr_row < HEIGHT_5) && (bus.wr_col < WIDTH_4)) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_board_row_server.sv
// Scoreboard bench for board_row_server: a request-level model predicts each
// committed row and its commit edge; a negedge monitor checks the DUT.
module tb_board_row_server;
  localparam int W = 10;
  localparam int H = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  board_row_server_if bus ();

  board_row_server dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cells [W];
    int          edge_n;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] mem_m [H][W];
  logic [15:0] m_cells [W];
  logic [15:0] last_row [W];
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  int          m_row = 0;
  bit          m_pend = 1'b0;
  int          m_pend_row = 0;
  bit          rst_edge = 1'b0;
  bit          mon_en = 1'b0;
  bit          prev_rdy = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: a fetch started at edge s reads cell c from memory as it
  // stood just before edge s+1+c and commits at edge s+W+1.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      rst_edge = 1'b1;
    end else begin
      rst_edge = 1'b0;
      if (m_active && cyc >= m_start + 1 && cyc <= m_start + W)
        m_cells[cyc - m_start - 1] = (m_row >= H) ? 16'h0000 : mem_m[m_row][cyc - m_start - 1];
      if (m_active && cyc == m_start + W + 1) begin
        e.cells  = m_cells;
        e.edge_n = cyc;
        exp_q.push_back(e);
        if (bus.LD_Row) begin
          m_start = cyc; m_row = int'(bus.rowNum); m_pend = 1'b0;
        end else if (m_pend) begin
          m_start = cyc; m_row = m_pend_row; m_pend = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end else if (m_active) begin
        if (bus.LD_Row) begin
          m_pend = 1'b1; m_pend_row = int'(bus.rowNum);
        end
      end else if (bus.LD_Row) begin
        m_active = 1'b1; m_start = cyc; m_row = int'(bus.rowNum);
      end
      if (bus.wr_en && int'(bus.wr_row) < H && int'(bus.wr_col) < W)
        mem_m[bus.wr_row][bus.wr_col] = bus.wr_data;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (mon_en) begin
      if (rst_edge) begin
        for (int i = 0; i < W; i++) last_row[i] = 16'h0000;
      end
      checks++;
      if (bus.busy !== m_active) begin
        errors++;
        $display("FAIL busy @%0d: got %b want %b", cyc, bus.busy, m_active);
      end
      if (bus.rowReady === 1'b1) begin
        checks++;
        if (prev_rdy) begin
          errors++;
          $display("FAIL rowReady_width @%0d: high two cycles in a row", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_commit @%0d: rowReady=1 with no commit expected", cyc);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (e.edge_n != cyc) begin
            errors++;
            $display("FAIL commit_edge: got edge %0d want edge %0d", cyc, e.edge_n);
          end
          checks++;
          bad = -1;
          for (int i = W - 1; i >= 0; i--) if (bus.Row[i] !== e.cells[i]) bad = i;
          if (bad >= 0) begin
            errors++;
            $display("FAIL commit_row @%0d: Row[%0d] got %h want %h", cyc, bad, bus.Row[bad], e.cells[bad]);
          end
          last_row = e.cells;
        end
      end else begin
        checks++;
        bad = (bus.rowReady !== 1'b0) ? W : -1;
        for (int i = W - 1; i >= 0; i--) if (bus.Row[i] !== last_row[i]) bad = i;
        if (bad == W) begin
          errors++;
          $display("FAIL rowReady_level @%0d: got %b want 0", cyc, bus.rowReady);
        end else if (bad >= 0) begin
          errors++;
          $display("FAIL row_stable @%0d: Row[%0d] got %h want %h", cyc, bad, bus.Row[bad], last_row[bad]);
        end
      end
      prev_rdy = (bus.rowReady === 1'b1);
    end
  end

  task automatic pulse(input logic [7:0] r);
    bus.LD_Row = 1'b1;
    bus.rowNum = r;
    @(negedge clk);
    bus.LD_Row = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.busy !== 1'b0 || m_active) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, bus.busy, n);
    end
    @(negedge clk);
  endtask

  task automatic check_cell(input string name, input int c, input logic [15:0] want);
    checks++;
    if (bus.Row[c] !== want) begin
      errors++;
      $display("FAIL %s: Row[%0d] got %h want %h", name, c, bus.Row[c], want);
    end
  endtask

  initial begin
    bus.LD_Row  = 1'b0;
    bus.rowNum  = 8'h00;
    bus.wr_en   = 1'b0;
    bus.wr_row  = 5'd0;
    bus.wr_col  = 4'd0;
    bus.wr_data = 16'h0000;
    reset_n     = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < W; c++) check_cell("reset_row", c, 16'h0000);

    // Fill every cell so no fetch sees uninitialised memory.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        bus.wr_en  = 1'b1;
        bus.wr_row = 5'(r);
        bus.wr_col = 4'(c);
        if (r == 3)                bus.wr_data = 16'h0100 + 16'(c);
        else if (r == 5)           bus.wr_data = 16'h5500 + 16'(c);
        else if (r == 7)           bus.wr_data = 16'h7700 + 16'(c);
        else if (r == 4 && c == 6) bus.wr_data = 16'h1234;
        else                       bus.wr_data = 16'($urandom);
        @(negedge clk);
      end
    end
    bus.wr_en = 1'b0;
    @(negedge clk);

    pulse(8'd3);
    wait_idle("basic");
    for (int c = 0; c < W; c++) check_cell("basic_row3", c, 16'h0100 + 16'(c));

    pulse(8'd25);
    wait_idle("oor25");
    for (int c = 0; c < W; c++) check_cell("oor_row25", c, 16'h0000);
    pulse(8'd3);
    wait_idle("refetch3");
    pulse(8'hFF);
    wait_idle("oor255");
    check_cell("oor_row255", 0, 16'h0000);

    pulse(8'd2);
    repeat (2) @(negedge clk);
    pulse(8'd5);
    repeat (2) @(negedge clk);
    pulse(8'd7);
    wait_idle("queued");
    for (int c = 0; c < W; c++) check_cell("queued_row7", c, 16'h7700 + 16'(c));

    pulse(8'd4);
    repeat (6) @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_row = 5'd4; bus.wr_col = 4'd6; bus.wr_data = 16'hABCD;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_idle("collide");
    check_cell("collide_old", 6, 16'h1234);
    pulse(8'd4);
    wait_idle("collide2");
    check_cell("collide_new", 6, 16'hABCD);

    pulse(8'd9);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < W; c++) check_cell("midreset_row", c, 16'h0000);
    pulse(8'd3);
    wait_idle("after_reset");
    check_cell("after_reset_row3", 9, 16'h0109);

    for (int i = 0; i < 400; i++) begin
      bus.LD_Row  = ($urandom_range(0, 7) == 0);
      bus.rowNum  = 8'($urandom_range(0, 24));
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_row  = 5'($urandom_range(0, 31));
      bus.wr_col  = 4'($urandom_range(0, 15));
      bus.wr_data = 16'($urandom);
      @(negedge clk);
    end
    bus.LD_Row = 1'b0;
    bus.wr_en  = 1'b0;
    wait_idle("random");
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_commits: %0d expected commits never seen, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
